window3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator for the salt-and-pepper median filter path. It accepts one pixel per cycle in raster order and buffers two prior lines internally. For each accepted pixel that completes a full 3x3 neighbourhood, it presents the nine pixels plus the centre coordinates, registered, to the combinational median-of-9 stage directly downstream. There is no backpressure, because the downstream stage is purely combinational.

---
 rtl/window3x3_gen.sv | 118 +++++++++++
 tb/tb_window3x3_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
// rtl/window3x3_gen.sv - streaming 3x3 neighbourhood generator with two line buffers
module window3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          pix_in,
  input  logic                       pix_valid,
  input  logic                       sof,
  output logic [DATA_W-1:0]          a0,
  output logic [DATA_W-1:0]          a1,
  output logic [DATA_W-1:0]          a2,
  output logic [DATA_W-1:0]          a3,
  output logic [DATA_W-1:0]          a4,
  output logic [DATA_W-1:0]          a5,
  output logic [DATA_W-1:0]          a6,
  output logic [DATA_W-1:0]          a7,
  output logic [DATA_W-1:0]          a8,
  output logic                       win_valid,
  output logic [$clog2(IMG_W)-1:0]   cx,
  output logic [$clog2(IMG_H)-1:0]   cy,
  output logic                       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // Running raster position of the next pixel expected.
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Effective position of the pixel being accepted (sof forces the origin).
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;
  logic          col_last;
  logic          row_last;
  logic          win_hit;
  logic          frame_hit;

  // Line buffers: lb1 holds line r-1, lb2 holds line r-2. Contents are never
  // reset; rows 0 and 1 are never flagged, so stale data cannot escape.
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] lb2_rd;

  // Resolve pixel position, next counter values and window qualification.
  always_comb begin
    c         = sof ? '0 : col;
    r         = sof ? '0 : row;
    col_last  = (c == CW'(IMG_W - 1));
    row_last  = (r == RW'(IMG_H - 1));
    col_nxt   = col_last ? '0 : c + CW'(1);
    row_nxt   = r;
    if (col_last) begin
      row_nxt = row_last ? '0 : r + RW'(1);
    end
    lb1_rd    = lb1[c];
    lb2_rd    = lb2[c];
    win_hit   = (r >= RW'(2)) && (c >= CW'(2));
    frame_hit = win_hit && row_last && col_last;
  end

  // Line-buffer RAM update; reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2[c] <= lb1_rd;
      lb1[c] <= pix_in;
    end
  end

  // Position counters, window shift register and registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      a0         <= '0;
      a1         <= '0;
      a2         <= '0;
      a3         <= '0;
      a4         <= '0;
      a5         <= '0;
      a6         <= '0;
      a7         <= '0;
      a8         <= '0;
      cx         <= '0;
      cy         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (pix_valid) begin
      col        <= col_nxt;
      row        <= row_nxt;
      a0         <= a1;
      a1         <= a2;
      a2         <= lb2_rd;
      a3         <= a4;
      a4         <= a5;
      a5         <= lb1_rd;
      a6         <= a7;
      a7         <= a8;
      a8         <= pix_in;
      win_valid  <= win_hit;
      frame_done <= frame_hit;
      if (win_hit) begin
        cx <= c - CW'(1);
        cy <= r - RW'(1);
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window3x3_gen.sv
// tb/tb_window3x3_gen.sv - directed self-checking bench for window3x3_gen
module tb_window3x3_gen;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int NX = W - 2;
  localparam int NW = (W - 2) * (H - 2);

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          sof;
  logic [DW-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic          win_valid;
  logic [2:0]    cx;
  logic [1:0]    cy;
  logic          frame_done;

  window3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
    .win_valid(win_valid), .cx(cx), .cy(cy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0][7:0] a;
    logic [2:0]      cx;
    logic [1:0]      cy;
    logic            fd;
    logic [31:0]     acc;
  } win_t;

  win_t        win_q[$];
  int          checks;
  int          errors;
  int          acc_cnt;
  int          idle_err;
  logic        last_acc;

  initial begin
    acc_cnt  = 0;
    idle_err = 0;
    last_acc = 1'b0;
  end

  always @(posedge clk) begin
    last_acc = (pix_valid === 1'b1) && (rst_n === 1'b1);
    if (last_acc) acc_cnt++;
  end

  always @(negedge clk) begin
    win_t e;
    if (win_valid === 1'b1) begin
      e.a   = {a8, a7, a6, a5, a4, a3, a2, a1, a0};
      e.cx  = cx;
      e.cy  = cy;
      e.fd  = frame_done;
      e.acc = acc_cnt;
      win_q.push_back(e);
      if (!last_acc) idle_err++;
    end
  end

  function automatic logic [7:0] ep(int base, int r, int c);
    return 8'(base + 16 * r + c);
  endfunction

  task automatic drive_pix(input logic [7:0] d, input logic s);
    pix_in    = d;
    pix_valid = 1'b1;
    sof       = s;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic feed_frame(input int base, input logic use_sof, input int max_gap);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (max_gap > 0) begin
          repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
          end
        end
        drive_pix(ep(base, r, c), use_sof && r == 0 && c == 0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++; if (a0 !== 8'h00) begin errors++; $display("FAIL reset_a0 got %h exp 00", a0); end
    checks++; if (a4 !== 8'h00) begin errors++; $display("FAIL reset_a4 got %h exp 00", a4); end
    checks++; if (a8 !== 8'h00) begin errors++; $display("FAIL reset_a8 got %h exp 00", a8); end
    checks++; if (cx !== 3'd0) begin errors++; $display("FAIL reset_cx got %0d exp 0", cx); end
    checks++; if (cy !== 2'd0) begin errors++; $display("FAIL reset_cy got %0d exp 0", cy); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got %b exp 0", win_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_frame;
    int acc0;
    win_q.delete();
    acc0 = acc_cnt;
    feed_frame(0, 1'b1, 0);
    checks++; if (win_q.size() != NW) begin errors++; $display("FAIL frame_count got %0d exp %0d", win_q.size(), NW); end
    if (win_q.size() > 0) begin
      checks++;
      if (win_q[0].acc - acc0 != 13) begin errors++; $display("FAIL first_latency got %0d exp 13", win_q[0].acc - acc0); end
    end
    for (int i = 0; i < NW && i < win_q.size(); i++) begin
      int x = 1 + i % NX;
      int y = 1 + i / NX;
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (win_q[i].a[k] !== ep(0, y - 1 + k / 3, x - 1 + k % 3)) begin
          errors++; $display("FAIL frame_win%0d_a%0d got %h exp %h", i, k, win_q[i].a[k], ep(0, y - 1 + k / 3, x - 1 + k % 3));
        end
      end
      checks++; if (win_q[i].cx !== 3'(x)) begin errors++; $display("FAIL frame_win%0d_cx got %0d exp %0d", i, win_q[i].cx, x); end
      checks++; if (win_q[i].cy !== 2'(y)) begin errors++; $display("FAIL frame_win%0d_cy got %0d exp %0d", i, win_q[i].cy, y); end
      checks++; if (win_q[i].fd !== (i == NW - 1)) begin errors++; $display("FAIL frame_win%0d_fd got %b exp %b", i, win_q[i].fd, i == NW - 1); end
    end
    if (win_q.size() == NW) begin
      checks++; if (win_q[NW-1].a[8] !== 8'h34) begin errors++; $display("FAIL last_a8 got %h exp 34", win_q[NW-1].a[8]); end
    end
  endtask

  task automatic test_gaps;
    win_q.delete();
    idle_err = 0;
    feed_frame(0, 1'b1, 3);
    checks++; if (win_q.size() != NW) begin errors++; $display("FAIL gaps_count got %0d exp %0d", win_q.size(), NW); end
    checks++; if (idle_err != 0) begin errors++; $display("FAIL gaps_idle_valid got %0d exp 0", idle_err); end
    for (int i = 0; i < NW && i < win_q.size(); i++) begin
      int x = 1 + i % NX;
      int y = 1 + i / NX;
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (win_q[i].a[k] !== ep(0, y - 1 + k / 3, x - 1 + k % 3)) begin
          errors++; $display("FAIL gaps_win%0d_a%0d got %h exp %h", i, k, win_q[i].a[k], ep(0, y - 1 + k / 3, x - 1 + k % 3));
        end
      end
      checks++; if (win_q[i].cx !== 3'(x)) begin errors++; $display("FAIL gaps_win%0d_cx got %0d exp %0d", i, win_q[i].cx, x); end
      checks++; if (win_q[i].cy !== 2'(y)) begin errors++; $display("FAIL gaps_win%0d_cy got %0d exp %0d", i, win_q[i].cy, y); end
      checks++; if (win_q[i].fd !== (i == NW - 1)) begin errors++; $display("FAIL gaps_win%0d_fd got %b exp %b", i, win_q[i].fd, i == NW - 1); end
    end
  endtask

  task automatic test_back_to_back;
    win_q.delete();
    feed_frame(0, 1'b1, 0);
    feed_frame(8'h80, 1'b1, 0);
    checks++; if (win_q.size() != 2 * NW) begin errors++; $display("FAIL b2b_count got %0d exp %0d", win_q.size(), 2 * NW); end
    for (int i = NW; i < 2 * NW && i < win_q.size(); i++) begin
      int x = 1 + (i - NW) % NX;
      int y = 1 + (i - NW) / NX;
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (win_q[i].a[k] !== ep(8'h80, y - 1 + k / 3, x - 1 + k % 3)) begin
          errors++; $display("FAIL b2b_win%0d_a%0d got %h exp %h", i, k, win_q[i].a[k], ep(8'h80, y - 1 + k / 3, x - 1 + k % 3));
        end
      end
      checks++; if (win_q[i].cx !== 3'(x)) begin errors++; $display("FAIL b2b_win%0d_cx got %0d exp %0d", i, win_q[i].cx, x); end
      checks++; if (win_q[i].cy !== 2'(y)) begin errors++; $display("FAIL b2b_win%0d_cy got %0d exp %0d", i, win_q[i].cy, y); end
      checks++; if (win_q[i].fd !== (i == 2 * NW - 1)) begin errors++; $display("FAIL b2b_win%0d_fd got %b exp %b", i, win_q[i].fd, i == 2 * NW - 1); end
    end
  endtask

  task automatic test_sof_mid;
    int acc0;
    win_q.delete();
    for (int p = 0; p < 9; p++) drive_pix(ep(0, p / W, p % W), p == 0);
    acc0 = acc_cnt;
    feed_frame(8'h40, 1'b1, 0);
    checks++; if (win_q.size() != NW) begin errors++; $display("FAIL sofmid_count got %0d exp %0d", win_q.size(), NW); end
    if (win_q.size() > 0) begin
      checks++;
      if (win_q[0].acc - acc0 != 13) begin errors++; $display("FAIL sofmid_latency got %0d exp 13", win_q[0].acc - acc0); end
    end
    for (int i = 0; i < NW && i < win_q.size(); i++) begin
      int x = 1 + i % NX;
      int y = 1 + i / NX;
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (win_q[i].a[k] !== ep(8'h40, y - 1 + k / 3, x - 1 + k % 3)) begin
          errors++; $display("FAIL sofmid_win%0d_a%0d got %h exp %h", i, k, win_q[i].a[k], ep(8'h40, y - 1 + k / 3, x - 1 + k % 3));
        end
      end
      checks++; if (win_q[i].cx !== 3'(x)) begin errors++; $display("FAIL sofmid_win%0d_cx got %0d exp %0d", i, win_q[i].cx, x); end
      checks++; if (win_q[i].cy !== 2'(y)) begin errors++; $display("FAIL sofmid_win%0d_cy got %0d exp %0d", i, win_q[i].cy, y); end
    end
  endtask

  task automatic test_reset_mid;
    int acc0;
    for (int p = 0; p < 18; p++) drive_pix(ep(0, p / W, p % W), p == 0);
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b exp 1", win_valid); end
    checks++; if (a8 !== 8'h32) begin errors++; $display("FAIL rstmid_pre_a8 got %h exp 32", a8); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", win_valid); end
    checks++; if (a8 !== 8'h00) begin errors++; $display("FAIL rstmid_a8 got %h exp 00", a8); end
    checks++; if (a0 !== 8'h00) begin errors++; $display("FAIL rstmid_a0 got %h exp 00", a0); end
    checks++; if (cx !== 3'd0) begin errors++; $display("FAIL rstmid_cx got %0d exp 0", cx); end
    checks++; if (cy !== 2'd0) begin errors++; $display("FAIL rstmid_cy got %0d exp 0", cy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    win_q.delete();
    acc0 = acc_cnt;
    feed_frame(8'h20, 1'b0, 0);
    checks++; if (win_q.size() != NW) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", win_q.size(), NW); end
    if (win_q.size() > 0) begin
      checks++;
      if (win_q[0].acc - acc0 != 13) begin errors++; $display("FAIL rstmid_latency got %0d exp 13", win_q[0].acc - acc0); end
    end
    for (int i = 0; i < NW && i < win_q.size(); i++) begin
      int x = 1 + i % NX;
      int y = 1 + i / NX;
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (win_q[i].a[k] !== ep(8'h20, y - 1 + k / 3, x - 1 + k % 3)) begin
          errors++; $display("FAIL rstmid_win%0d_a%0d got %h exp %h", i, k, win_q[i].a[k], ep(8'h20, y - 1 + k / 3, x - 1 + k % 3));
        end
      end
      checks++; if (win_q[i].cx !== 3'(x)) begin errors++; $display("FAIL rstmid_win%0d_cx got %0d exp %0d", i, win_q[i].cx, x); end
      checks++; if (win_q[i].cy !== 2'(y)) begin errors++; $display("FAIL rstmid_win%0d_cy got %0d exp %0d", i, win_q[i].cy, y); end
      checks++; if (win_q[i].fd !== (i == NW - 1)) begin errors++; $display("FAIL rstmid_win%0d_fd got %b exp %b", i, win_q[i].fd, i == NW - 1); end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pix_in    = '0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    rst_n     = 1'b1;
    test_reset();
    test_first_frame();
    test_gaps();
    test_back_to_back();
    test_sof_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
